// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  localparam logic [1:0] DBITS_5 = 2'd0;
  localparam logic [1:0] DBITS_6 = 2'd1;
  localparam logic [1:0] DBITS_7 = 2'd2;
  localparam logic [1:0] DBITS_8 = 2'd3;
  localparam int         DBITS_BASE = 5;

  typedef struct packed {
    logic [1:0] data_bits;
    logic [1:0] parity;
    logic       stop2;
  } frame_cfg_t;

  // Start + data + optional parity + stop bits; reserved parity counts as none.
  function automatic logic [3:0] frame_bits(input frame_cfg_t cfg);
    logic [3:0] n;
    n = 4'd1 + {2'b00, cfg.data_bits} + 4'd5;
    if ((cfg.parity == PAR_EVEN) || (cfg.parity == PAR_ODD)) begin
      n = n + 4'd1;
    end else begin
      n = n + 4'd0;
    end
    n = n + (cfg.stop2 ? 4'd2 : 4'd1);
    return n;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular TX FIFO; the level counter carries the extra bit separating full from empty.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full      = (level_r == LVL_W'(DEPTH));
  assign empty     = (level_r == {LVL_W{1'b0}});
  assign level     = level_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + {{(LVL_W-1){1'b0}}, 1'b1};
        2'b01:   level_r <= level_r - {{(LVL_W-1){1'b0}}, 1'b1};
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with buffered input.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DIV_W-1:0]              cfg_baud_div,
  input  logic [1:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [BIT_W-1:0] BIT_ONE = {{(BIT_W-1){1'b0}}, 1'b1};

  tx_state_e         state_r, state_nxt_s;
  logic [DIV_W-1:0]  cnt_r, cnt_nxt_s;
  logic [BIT_W-1:0]  bit_r, bit_nxt_s, bit_inc_s, last_bit_s;
  logic              stop_r, stop_nxt_s;
  logic              tx_r, tx_nxt_s;
  logic              pop_s, push_s, empty_s, full_s;
  logic [DATA_W-1:0] head_s;
  logic [LVL_W-1:0]  level_s;
  logic [DATA_W-1:0] data_r;
  logic [DIV_W-1:0]  div_r;
  logic [1:0]        dbits_r;
  logic [1:0]        par_r;
  logic              stop2_r;
  logic              cnt_zero_s, par_en_s, parity_bit_s;

  // Parity over the first bits_code+5 data bits only; odd parity seeds the accumulator with 1.
  function automatic logic calc_parity(input logic [DATA_W-1:0] d, input logic [1:0] bits_code,
                                       input logic odd);
    logic acc;
    acc = odd;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < (int'(bits_code) + DBITS_BASE)) begin
        acc = acc ^ d[i];
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

  assign push_s     = tx_valid && !full_s;
  assign tx_ready   = !full_s;
  assign tx         = tx_r;
  assign busy       = (state_r != IDLE) || (level_s != {LVL_W{1'b0}});
  assign fifo_level = level_s;

`ifdef UART_TX_FIFO_EN
  uart_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_s),
    .wdata   (tx_data),
    .pop     (pop_s),
    .rdata   (head_s),
    .empty   (empty_s),
    .full    (full_s),
    .level   (level_s)
  );
`else
  logic [DATA_W-1:0] holding_r;
  logic              hold_full_r;

  assign empty_s = !hold_full_r;
  assign full_s  = hold_full_r;
  assign head_s  = holding_r;
  assign level_s = {{(LVL_W-1){1'b0}}, hold_full_r};

  // Single-entry lookahead buffer, refilled while the shifter is busy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      holding_r   <= {DATA_W{1'b0}};
      hold_full_r <= 1'b0;
    end else if (push_s) begin
      holding_r   <= tx_data;
      hold_full_r <= 1'b1;
    end else if (pop_s) begin
      hold_full_r <= 1'b0;
    end
  end
`endif

  assign cnt_zero_s   = (cnt_r == {DIV_W{1'b0}});
  assign par_en_s     = (par_r == PAR_EVEN) || (par_r == PAR_ODD);
  assign parity_bit_s = calc_parity(data_r, dbits_r, par_r == PAR_ODD);
  assign bit_inc_s    = bit_r + BIT_ONE;
  assign last_bit_s   = BIT_W'(dbits_r) + BIT_W'(3'd4);

  // Next state, counters and the line value the tx flop takes at the next edge
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r - CNT_ONE;
    bit_nxt_s   = bit_r;
    stop_nxt_s  = stop_r;
    tx_nxt_s    = 1'b1;
    pop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = START;
          cnt_nxt_s   = cfg_baud_div;
          tx_nxt_s    = 1'b0;
        end else begin
          cnt_nxt_s = {DIV_W{1'b0}};
          tx_nxt_s  = 1'b1;
        end
      end
      START: begin
        tx_nxt_s = 1'b0;
        if (cnt_zero_s) begin
          state_nxt_s = DATA;
          bit_nxt_s   = {BIT_W{1'b0}};
          cnt_nxt_s   = div_r;
          tx_nxt_s    = data_r[0];
        end else begin
          tx_nxt_s = 1'b0;
        end
      end
      DATA: begin
        tx_nxt_s = data_r[bit_r];
        if (cnt_zero_s) begin
          cnt_nxt_s = div_r;
          if (bit_r == last_bit_s) begin
            if (par_en_s) begin
              state_nxt_s = PARITY;
              tx_nxt_s    = parity_bit_s;
            end else begin
              state_nxt_s = STOP;
              stop_nxt_s  = 1'b0;
              tx_nxt_s    = 1'b1;
            end
          end else begin
            bit_nxt_s = bit_inc_s;
            tx_nxt_s  = data_r[bit_inc_s];
          end
        end else begin
          tx_nxt_s = data_r[bit_r];
        end
      end
      PARITY: begin
        tx_nxt_s = parity_bit_s;
        if (cnt_zero_s) begin
          state_nxt_s = STOP;
          cnt_nxt_s   = div_r;
          stop_nxt_s  = 1'b0;
          tx_nxt_s    = 1'b1;
        end else begin
          tx_nxt_s = parity_bit_s;
        end
      end
      STOP: begin
        tx_nxt_s = 1'b1;
        if (cnt_zero_s) begin
          if (stop2_r && !stop_r) begin
            stop_nxt_s = 1'b1;
            cnt_nxt_s  = div_r;
          end else if (!empty_s) begin
            // Chain straight into the next start bit with no idle gap
            pop_s       = 1'b1;
            state_nxt_s = START;
            cnt_nxt_s   = cfg_baud_div;
            tx_nxt_s    = 1'b0;
          end else begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = {DIV_W{1'b0}};
          end
        end else begin
          tx_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {DIV_W{1'b0}};
        tx_nxt_s    = 1'b1;
      end
    endcase
  end

  // FSM, counters, tx flop and the per-frame config shadow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= {DIV_W{1'b0}};
      bit_r   <= {BIT_W{1'b0}};
      stop_r  <= 1'b0;
      tx_r    <= 1'b1;
      data_r  <= {DATA_W{1'b0}};
      div_r   <= {DIV_W{1'b0}};
      dbits_r <= 2'd0;
      par_r   <= 2'd0;
      stop2_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      bit_r   <= bit_nxt_s;
      stop_r  <= stop_nxt_s;
      tx_r    <= tx_nxt_s;
      if (pop_s) begin
        data_r  <= head_s;
        div_r   <= cfg_baud_div;
        dbits_r <= cfg_data_bits;
        par_r   <= cfg_parity;
        stop2_r <= cfg_stop2;
      end
    end
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
- Parametrised, runtime-configurable UART transmitter; next generation of the fixed 8N1 transmitter.
- Accepts bytes over a valid/ready handshake and buffers them.
- Serialises each byte LSB-first with programmable data length, parity, stop bits and bit period.
- Sits between the bus-side register block and the pad; drives the serial TX line.

Parameters:
- DIV_W, 16, width of the bit-period divisor.
- FIFO_DEPTH, 8, TX buffer entries; power of two, >=2. Used only with the FIFO feature.
- DATA_W, 8, maximum data bits per frame; the data input width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous reset, active-low.
- cfg_baud_div  in  DIV_W  bit period minus one, in clk cycles.
- cfg_data_bits  in  2  data length: 0=5, 1=6, 2=7, 3=8 bits; must be <= DATA_W.
- cfg_parity  in  2  0=none, 1=even, 2=odd, 3=reserved (treated as none).
- cfg_stop2  in  1  0=one stop bit, 1=two stop bits.
- tx_data  in  DATA_W  byte to send.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  buffer can accept; transfer occurs when tx_valid && tx_ready.
- tx  out  1  serial output, idle high.
- busy  out  1  frame in progress or buffer non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  buffered entries; reads 0 or 1 without the FIFO feature.

Behaviour:
- Reset values: tx=1, busy=0, tx_ready=1, fifo_level=0. FSM=IDLE, counters cleared, buffer emptied.
- Reset mid-frame aborts the frame; tx returns to 1 asynchronously.
- Bit period is cfg_baud_div+1 clocks. cfg_baud_div=0 gives one clock per bit.
- A baud counter reloads at each state/bit boundary.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or -> START directly if the buffer is non-empty.
- IDLE: when the buffer is non-empty, pop the head and latch all cfg_* into a frame shadow. Enter START on the next clock.
  - Config changes mid-frame never affect the current frame.
- START: tx=0 for one bit period.
- DATA: shift out cfg_data_bits+5 bits, LSB first. A bit index counter runs from 0 to N-1.
- PARITY: entered only when the latched parity is 1 or 2.
  - Even parity: tx = XOR of the sent data bits.
  - Odd parity: tx = inverted XOR of the sent data bits.
  - Bits above the frame length are ignored.
- STOP: tx=1 for one period, or two periods if cfg_stop2 was latched.
- Back-to-back frames: no idle gap. The next START begins the clock after the final stop-bit period ends.
- tx is driven from a flop, so there are no combinational glitches. First start-bit edge: 1 clock after the pop decision.
- busy = (state != IDLE) || (level != 0).
- Full buffer: tx_ready=0, and tx_valid is ignored (no overwrite).
- Push and pop in the same cycle when full: the pop frees a slot but tx_ready is registered-full-based, so the push is refused that cycle.
- Push and pop in the same cycle when not full: level is unchanged.
- Pointers wrap modulo FIFO_DEPTH. An extra level bit distinguishes full from empty.

Optional Feature:
- Macro: UART_TX_FIFO_EN.
- Defined: buffer is a FIFO_DEPTH-entry circular FIFO (sub-module uart_tx_fifo).
- Undefined: buffer is a single holding register.
  - tx_ready = !holding_full.
  - Holding reg is loaded while the shifter transmits, giving one frame of lookahead.
  - fifo_level reflects holding_full (0/1).
  - FIFO_DEPTH is ignored.
- FSM and line timing are identical in both builds.

Decomposition:
- Package uart_pkg holds:
  - typedef enum tx_state_e {IDLE, START, DATA, PARITY, STOP}.
  - enum parity_e {PAR_NONE, PAR_EVEN, PAR_ODD}.
  - Data-length encoding constants.
  - Function frame_bits(cfg) returning the total bits per frame.
- One sub-module is natural: uart_tx_fifo (push/pop, full/empty, level), instantiated under UART_TX_FIFO_EN.

Test Plan:
- Reset, baud_div=3, 8N1, push 0xA5 → tx sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 4 clocks; frame lasts 40 clocks; busy low after.
- 7E2, baud_div=0, push 0x35 → start 0, data 1,0,1,0,1,1,0, parity 0 (4 ones), stop 1,1; frame lasts 11 clocks.
- 5O1, baud_div=1, push 0xFF → 5 data ones, odd parity bit 0 (odd count), extra bits ignored; 8 bits x 2 clocks = 16 clocks.
- FIFO build, DEPTH=8: push 9 bytes while busy → tx_ready drops after the 8th accepted; fifo_level peaks at 8; all 8 bytes sent back-to-back with no idle gap between stop and start.
- Change cfg_baud_div from 3 to 7 mid-frame → current frame keeps 4 clk/bit, next frame uses 8 clk/bit.
- Assert reset_n low during a DATA bit → tx=1 immediately, fifo_level=0; after release, tx stays idle until a new push.
